// File: rtl/cellrv32_icache_nway_if.sv
// rtl/cellrv32_icache_nway_if.sv - host fetch and processor bus bundle for the N-way i-cache
// Purpose: groups the host fetch port and the processor bus port of cellrv32_icache_nway.
// Modports: master = fetch unit / bus fabric side (drives host_*_i, bus_*_i),
//           slave  = cache side (drives host_*_o, bus_*_o).
interface cellrv32_icache_nway_if;
   logic [31:0] host_addr_i;
   logic [31:0] host_rdata_o;
   logic        host_re_i;
   logic        host_ack_o;
   logic        host_err_o;
   logic        bus_cached_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_rdata_i;
   logic        bus_re_o;
   logic        bus_ack_i;
   logic        bus_err_i;

   modport master (
      output host_addr_i, host_re_i, bus_rdata_i, bus_ack_i, bus_err_i,
      input  host_rdata_o, host_ack_o, host_err_o, bus_cached_o, bus_addr_o, bus_re_o
   );
   modport slave (
      input  host_addr_i, host_re_i, bus_rdata_i, bus_ack_i, bus_err_i,
      output host_rdata_o, host_ack_o, host_err_o, bus_cached_o, bus_addr_o, bus_re_o
   );
endinterface

// File: rtl/cellrv32_icache_nway.sv
// rtl/cellrv32_icache_nway.sv - N-way set-associative i-cache with tree PLRU and uncached window
// Purpose: 1/2/4-way instruction cache between CPU fetch and the processor bus.
// Ports: clk_i, rstn_i (async active-low), clear_i (invalidate all), miss_o (1-cycle miss pulse),
//        bus_if (slave modport: host fetch port + processor bus port).
// Optional: CELLRV32_ICACHE_STATS_EN adds stat_hit_o / stat_miss_o saturating counters.
module cellrv32_icache_nway #(
   parameter int         ICACHE_NUM_LINES  = 8,
   parameter int         ICACHE_BLOCK_SIZE = 64,
   parameter int         ICACHE_NUM_WAYS   = 2,
   parameter logic [3:0] ICACHE_UC_BEGIN   = 4'hF
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  clear_i,
   output logic                  miss_o,
`ifdef CELLRV32_ICACHE_STATS_EN
   output logic [31:0]           stat_hit_o,
   output logic [31:0]           stat_miss_o,
`endif
   cellrv32_icache_nway_if.slave bus_if
);
   localparam int WORDS    = ICACHE_BLOCK_SIZE / 4;
   localparam int OFS_W    = $clog2(WORDS);
   localparam int IDX_W    = $clog2(ICACHE_NUM_LINES);
   localparam int TAG_W    = 30 - OFS_W - IDX_W;
   localparam int IDX_WE   = (IDX_W > 0) ? IDX_W : 1;
   localparam int DA_W     = $clog2(ICACHE_NUM_LINES * WORDS);
   localparam int DA_WE    = (DA_W > 0) ? DA_W : 1;
   localparam int WAY_W    = (ICACHE_NUM_WAYS > 1) ? $clog2(ICACHE_NUM_WAYS) : 1;
   localparam logic [31:0] OFS_MASK = 32'(ICACHE_BLOCK_SIZE - 1) & 32'hFFFF_FFFC;

   if (ICACHE_NUM_WAYS != 1 && ICACHE_NUM_WAYS != 2 && ICACHE_NUM_WAYS != 4) begin : g_bad_ways
      $error("cellrv32_icache_nway: ICACHE_NUM_WAYS must be 1, 2 or 4");
   end

   typedef enum logic [3:0] {
      S_IDLE, S_CLEAR, S_CHECK, S_MISS, S_REQ, S_GET, S_RESYNC0, S_RESYNC1, S_UC_REQ, S_UC_GET
   } state_t;

   function automatic logic [IDX_WE-1:0] f_idx(input logic [31:0] a);
      return IDX_WE'((a >> (2 + OFS_W)) & 32'(ICACHE_NUM_LINES - 1));
   endfunction

   // index and word offset are adjacent, so the data-array address is just the shifted address
   function automatic logic [DA_WE-1:0] f_da(input logic [31:0] a);
      return DA_WE'((a >> 2) & 32'(ICACHE_NUM_LINES * WORDS - 1));
   endfunction

   function automatic logic [TAG_W-1:0] f_tag(input logic [31:0] a);
      return TAG_W'(a >> (32 - TAG_W));
   endfunction

   // 4-way tree: root bit 0 picks odd (1) / even (0) ways, bit 1 picks way 2/0, bit 2 picks way 3/1.
   // Bits point at the side to evict next.
   function automatic logic [WAY_W-1:0] f_plru_way(input logic [2:0] p);
      logic [1:0] v;
      v = 2'd0;
      if (ICACHE_NUM_WAYS == 4)      v = p[0] ? {p[2], 1'b1} : {p[1], 1'b0};
      else if (ICACHE_NUM_WAYS == 2) v = {1'b0, p[0]};
      return WAY_W'(v);
   endfunction

   function automatic logic [2:0] f_plru_upd(input logic [2:0] p, input logic [1:0] w);
      logic [2:0] n;
      n    = p;
      n[0] = ~w[0];
      if (ICACHE_NUM_WAYS == 4) begin
         if (w[0]) n[2] = ~w[1];
         else      n[1] = ~w[1];
      end
      return n;
   endfunction

   state_t            r_state, w_next;
   logic              r_re_buf, r_clr_buf;
   logic [31:0]       r_addr;
   logic [WAY_W-1:0]  r_victim;

   logic [TAG_W-1:0]  r_tag   [ICACHE_NUM_WAYS][ICACHE_NUM_LINES];
   logic              r_valid [ICACHE_NUM_WAYS][ICACHE_NUM_LINES];
   logic [31:0]       r_data  [ICACHE_NUM_WAYS][ICACHE_NUM_LINES*WORDS];
   logic              r_werr  [ICACHE_NUM_WAYS][ICACHE_NUM_LINES*WORDS];
   logic [2:0]        r_plru  [ICACHE_NUM_LINES];

   logic [TAG_W-1:0]  r_rd_tag   [ICACHE_NUM_WAYS];
   logic              r_rd_valid [ICACHE_NUM_WAYS];
   logic [31:0]       r_rd_data  [ICACHE_NUM_WAYS];
   logic              r_rd_werr  [ICACHE_NUM_WAYS];

   logic              w_re_pend, w_clr_pend, w_uc, w_take, w_bus_fin, w_last;
   logic              w_hit, w_hit_err, w_inv_any, w_fill_err;
   logic [WAY_W-1:0]  w_hit_way, w_inv_way;
   logic [31:0]       w_hit_data, w_fill_data;
   logic [IDX_WE-1:0] w_rd_idx, w_fill_idx;
   logic [DA_WE-1:0]  w_rd_da, w_fill_da;

   assign w_re_pend  = bus_if.host_re_i | r_re_buf;
   assign w_clr_pend = clear_i | r_clr_buf;
   assign w_uc       = (bus_if.host_addr_i[31:28] >= ICACHE_UC_BEGIN);
   assign w_take     = (r_state == S_IDLE) && !w_clr_pend && w_re_pend;
   assign w_bus_fin  = bus_if.bus_ack_i | bus_if.bus_err_i;
   assign w_last     = ((r_addr & OFS_MASK) == OFS_MASK);
   assign w_rd_idx   = f_idx(bus_if.host_addr_i);
   assign w_rd_da    = f_da(bus_if.host_addr_i);
   assign w_fill_idx = f_idx(r_addr);
   assign w_fill_da  = f_da(r_addr);

   always_comb begin
      w_hit = 1'b0; w_hit_way = '0; w_hit_data = '0; w_hit_err = 1'b0;
      w_inv_any = 1'b0; w_inv_way = '0; w_fill_data = '0; w_fill_err = 1'b0;
      for (int w = 0; w < ICACHE_NUM_WAYS; w++) begin
         if (r_rd_valid[w] && (r_rd_tag[w] == f_tag(bus_if.host_addr_i))) begin
            w_hit = 1'b1; w_hit_way = WAY_W'(w); w_hit_data = r_rd_data[w]; w_hit_err = r_rd_werr[w];
         end
         if (WAY_W'(w) == r_victim) begin
            w_fill_data = r_rd_data[w]; w_fill_err = r_rd_werr[w];
         end
      end
      // descending scan so the lowest invalid way wins
      for (int w = ICACHE_NUM_WAYS - 1; w >= 0; w--) begin
         if (!r_rd_valid[w]) begin
            w_inv_any = 1'b1; w_inv_way = WAY_W'(w);
         end
      end
   end

   always_comb begin
      w_next              = r_state;
      miss_o              = 1'b0;
      bus_if.host_ack_o   = 1'b0;
      bus_if.host_err_o   = 1'b0;
      bus_if.host_rdata_o = '0;
      bus_if.bus_re_o     = 1'b0;
      bus_if.bus_cached_o = 1'b0;
      bus_if.bus_addr_o   = '0;
      case (r_state)
         S_IDLE: begin
            if (w_clr_pend)     w_next = S_CLEAR;
            else if (w_re_pend) w_next = w_uc ? S_UC_REQ : S_CHECK;
         end
         S_CLEAR: w_next = S_IDLE;
         S_CHECK: begin
            if (w_hit) begin
               bus_if.host_ack_o   = ~w_hit_err;
               bus_if.host_err_o   = w_hit_err;
               bus_if.host_rdata_o = w_hit_data;
               w_next              = S_IDLE;
            end else begin
               w_next = S_MISS;
            end
         end
         S_MISS: begin
            miss_o = 1'b1;
            w_next = S_REQ;
         end
         S_REQ: begin
            bus_if.bus_re_o     = 1'b1;
            bus_if.bus_cached_o = 1'b1;
            bus_if.bus_addr_o   = r_addr;
            w_next              = S_GET;
         end
         S_GET: begin
            bus_if.bus_cached_o = 1'b1;
            bus_if.bus_addr_o   = r_addr;
            if (w_bus_fin) w_next = w_last ? S_RESYNC0 : S_REQ;
         end
         S_RESYNC0: w_next = S_RESYNC1;
         S_RESYNC1: begin
            bus_if.host_ack_o   = ~w_fill_err;
            bus_if.host_err_o   = w_fill_err;
            bus_if.host_rdata_o = w_fill_data;
            w_next              = S_IDLE;
         end
         S_UC_REQ: begin
            bus_if.bus_re_o   = 1'b1;
            bus_if.bus_addr_o = {bus_if.host_addr_i[31:2], 2'b00};
            w_next            = S_UC_GET;
         end
         S_UC_GET: begin
            bus_if.bus_addr_o = {bus_if.host_addr_i[31:2], 2'b00};
            if (w_bus_fin) begin
               bus_if.host_ack_o   = ~bus_if.bus_err_i;
               bus_if.host_err_o   = bus_if.bus_err_i;
               bus_if.host_rdata_o = bus_if.bus_rdata_i;
               w_next              = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state   <= S_CLEAR;
         r_re_buf  <= 1'b0;
         r_clr_buf <= 1'b0;
         r_addr    <= '0;
         r_victim  <= '0;
      end else begin
         r_state   <= w_next;
         r_re_buf  <= (r_re_buf | bus_if.host_re_i) & ~w_take;
         r_clr_buf <= (r_state == S_CLEAR) ? clear_i : (r_clr_buf | clear_i);
         if (r_state == S_MISS) begin
            r_addr   <= bus_if.host_addr_i & ~32'(ICACHE_BLOCK_SIZE - 1);
            r_victim <= w_inv_any ? w_inv_way : f_plru_way(r_plru[w_rd_idx]);
         end else if ((r_state == S_GET) && w_bus_fin && !w_last) begin
            r_addr <= (r_addr & ~OFS_MASK) | ((r_addr + 32'd4) & OFS_MASK);
         end
      end
   end

   // array storage: valid/PLRU are cleared by S_CLEAR, which reset always passes through
   always_ff @(posedge clk_i) begin
      for (int w = 0; w < ICACHE_NUM_WAYS; w++) begin
         r_rd_tag[w]   <= r_tag[w][w_rd_idx];
         r_rd_valid[w] <= r_valid[w][w_rd_idx];
         r_rd_data[w]  <= r_data[w][w_rd_da];
         r_rd_werr[w]  <= r_werr[w][w_rd_da];
      end
      if (r_state == S_CLEAR) begin
         for (int l = 0; l < ICACHE_NUM_LINES; l++) begin
            for (int w = 0; w < ICACHE_NUM_WAYS; w++) r_valid[w][l] <= 1'b0;
            r_plru[l] <= 3'b000;
         end
      end
      if ((ICACHE_NUM_WAYS > 1) && (r_state == S_CHECK) && w_hit)
         r_plru[w_rd_idx] <= f_plru_upd(r_plru[w_rd_idx], 2'(w_hit_way));
      if ((r_state == S_GET) && w_bus_fin) begin
         for (int w = 0; w < ICACHE_NUM_WAYS; w++) begin
            if (WAY_W'(w) == r_victim) begin
               r_data[w][w_fill_da] <= bus_if.bus_rdata_i;
               r_werr[w][w_fill_da] <= bus_if.bus_err_i;
               if (w_last) begin
                  r_tag[w][w_fill_idx]   <= f_tag(r_addr);
                  r_valid[w][w_fill_idx] <= 1'b1;
               end
            end
         end
         if ((ICACHE_NUM_WAYS > 1) && w_last)
            r_plru[w_fill_idx] <= f_plru_upd(r_plru[w_fill_idx], 2'(r_victim));
      end
   end

`ifdef CELLRV32_ICACHE_STATS_EN
   logic [31:0] r_stat_hit, r_stat_miss;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_stat_hit  <= '0;
         r_stat_miss <= '0;
      end else if (r_state == S_CLEAR) begin
         r_stat_hit  <= '0;
         r_stat_miss <= '0;
      end else begin
         if ((r_state == S_CHECK) && w_hit && (r_stat_hit != 32'hFFFF_FFFF))
            r_stat_hit <= r_stat_hit + 32'd1;
         if ((r_state == S_MISS) && (r_stat_miss != 32'hFFFF_FFFF))
            r_stat_miss <= r_stat_miss + 32'd1;
      end
   end

   assign stat_hit_o  = r_stat_hit;
   assign stat_miss_o = r_stat_miss;
`endif
endmodule

// File: tb/tb_cellrv32_icache_nway.sv
// tb/tb_cellrv32_icache_nway.sv - directed self-checking bench for cellrv32_icache_nway (4 ways, 16 B blocks, 8 lines)
module tb_cellrv32_icache_nway;
   logic clk   = 1'b0;
   logic rstn  = 1'b0;
   logic clear = 1'b0;
   logic miss;

   always #5 clk = ~clk;

   cellrv32_icache_nway_if bif();

`ifdef CELLRV32_ICACHE_STATS_EN
   logic [31:0] stat_hit, stat_miss;
`endif

   cellrv32_icache_nway #(
      .ICACHE_NUM_LINES(8), .ICACHE_BLOCK_SIZE(16), .ICACHE_NUM_WAYS(4), .ICACHE_UC_BEGIN(4'hF)
   ) dut (
      .clk_i   (clk),
      .rstn_i  (rstn),
      .clear_i (clear),
      .miss_o  (miss),
`ifdef CELLRV32_ICACHE_STATS_EN
      .stat_hit_o  (stat_hit),
      .stat_miss_o (stat_miss),
`endif
      .bus_if  (bif)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ~a ^ 32'h1357_9BDF;
   endfunction

   // bus responder: one-cycle-later ack (or err on err_addr), logs every request
   logic [31:0] q_addr[$];
   logic        q_cached[$];
   logic [31:0] bm_addr;
   logic [31:0] err_addr = 32'h0;
   logic        err_en   = 1'b0;

   initial begin
      bif.bus_ack_i   = 1'b0;
      bif.bus_err_i   = 1'b0;
      bif.bus_rdata_i = 32'h0;
      forever begin
         @(posedge clk); #1;
         bif.bus_ack_i = 1'b0;
         bif.bus_err_i = 1'b0;
         if (bif.bus_re_o) begin
            bm_addr = bif.bus_addr_o;
            q_addr.push_back(bm_addr);
            q_cached.push_back(bif.bus_cached_o);
            @(posedge clk); #1;
            bif.bus_rdata_i = mem_word(bm_addr);
            if (err_en && (bm_addr == err_addr)) bif.bus_err_i = 1'b1;
            else                                 bif.bus_ack_i = 1'b1;
         end
      end
   end

   int          f_edges, f_miss, clr_at = -1;
   logic        f_done, f_ack, f_err;
   logic [31:0] f_data;

   // starts and ends on a falling edge; one idle cycle before the request
   task automatic fetch(input logic [31:0] a);
      @(negedge clk);
      q_addr.delete(); q_cached.delete();
      bif.host_addr_i = a;
      bif.host_re_i   = 1'b1;
      f_edges = 0; f_miss = 0; f_done = 1'b0; f_ack = 1'b0; f_err = 1'b0; f_data = '0;
      clear = (clr_at == 0);
      while (!f_done && (f_edges < 200)) begin
         @(posedge clk);
         f_edges++;
         @(negedge clk);
         bif.host_re_i = 1'b0;
         clear = (clr_at == f_edges);
         if (miss) f_miss++;
         if (bif.host_ack_o || bif.host_err_o) begin
            f_done = 1'b1; f_ack = bif.host_ack_o; f_err = bif.host_err_o; f_data = bif.host_rdata_o;
         end
      end
      clear  = 1'b0;
      clr_at = -1;
      check_val("fetch_done", 32'(f_done), 32'd1);
   endtask

   task automatic expect_fetch(input string tag, input logic [31:0] a, input int exp_miss,
                               input logic exp_err);
      fetch(a);
      check_val({tag, "_miss"}, 32'(f_miss), 32'(exp_miss));
      check_val({tag, "_ack"},  32'(f_ack),  32'(!exp_err));
      check_val({tag, "_err"},  32'(f_err),  32'(exp_err));
      if (!exp_err) check_val({tag, "_data"}, f_data, mem_word({a[31:2], 2'b00}));
   endtask

   int n;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bif.host_addr_i = 32'h0;
      bif.host_re_i   = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_miss",   32'(miss),             32'd0);
      check_val("rst_ack",    32'(bif.host_ack_o),   32'd0);
      check_val("rst_bus_re", 32'(bif.bus_re_o),     32'd0);
      check_val("rst_cached", 32'(bif.bus_cached_o), 32'd0);
      check_val("rst_baddr",  bif.bus_addr_o,        32'd0);
`ifdef CELLRV32_ICACHE_STATS_EN
      check_val("rst_stat_hit",  stat_hit,  32'd0);
      check_val("rst_stat_miss", stat_miss, 32'd0);
`endif
      rstn = 1'b1;

      // cold fetch: whole block from offset 0, ack with requested word
      expect_fetch("cold", 32'h0000_0104, 1, 1'b0);
      check_val("cold_nreq", 32'(q_addr.size()), 32'd4);
      for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
         check_val($sformatf("cold_addr%0d", i), q_addr[i], 32'h100 + 32'(4 * i));
         check_val($sformatf("cold_cached%0d", i), 32'(q_cached[i]), 32'd1);
      end

      // hit: 1 clock edge after the request cycle, no bus traffic
      expect_fetch("hit108", 32'h0000_0108, 0, 1'b0);
      check_val("hit_lat", 32'(f_edges), 32'd1);
      check_val("hit_nreq", 32'(q_addr.size()), 32'd0);

      // index-0 aliases: A=0x100 B=0x200 C=0x300 D=0x400 E=0x500
      expect_fetch("fillB", 32'h0000_0200, 1, 1'b0);
      expect_fetch("fillC", 32'h0000_0300, 1, 1'b0);
      expect_fetch("fillD", 32'h0000_0400, 1, 1'b0);
      expect_fetch("hitA",  32'h0000_0100, 0, 1'b0);
      expect_fetch("fillE", 32'h0000_0500, 1, 1'b0);
      expect_fetch("hitA2", 32'h0000_0100, 0, 1'b0);
      expect_fetch("missB", 32'h0000_0200, 1, 1'b0);
      expect_fetch("hitC",  32'h0000_0300, 0, 1'b0);

      // error on third refill word
      err_addr = 32'h0000_2048; err_en = 1'b1;
      expect_fetch("errfill", 32'h0000_2044, 1, 1'b0);
      expect_fetch("errword", 32'h0000_2048, 0, 1'b1);
      expect_fetch("errnbr",  32'h0000_204C, 0, 1'b0);
      err_en = 1'b0;

      // uncached window
      expect_fetch("uc1", 32'hF000_0010, 0, 1'b0);
      check_val("uc1_nreq",   32'(q_addr.size()), 32'd1);
      check_val("uc1_addr",   q_addr[0], 32'hF000_0010);
      check_val("uc1_cached", 32'(q_cached[0]), 32'd0);
      expect_fetch("uc2", 32'hF000_0012, 0, 1'b0);
      check_val("uc2_nreq", 32'(q_addr.size()), 32'd1);
      check_val("uc2_addr", q_addr[0], 32'hF000_0010);
      err_addr = 32'hF000_0014; err_en = 1'b1;
      expect_fetch("ucerr", 32'hF000_0014, 0, 1'b1);
      err_en = 1'b0;

      // clear during S_GET: current fetch completes, block then gone
      clr_at = 4;
      expect_fetch("clrget", 32'h0000_3004, 1, 1'b0);
      expect_fetch("clrget_re", 32'h0000_3004, 1, 1'b0);
      expect_fetch("hitA_clr", 32'h0000_0100, 1, 1'b0);

      // clear and read in the same idle cycle: clear first, then the read misses
      expect_fetch("pre_same", 32'h0000_3004, 0, 1'b0);
      clr_at = 0;
      expect_fetch("clr_same", 32'h0000_3004, 1, 1'b0);

      // reset during refill
      @(negedge clk);
      bif.host_addr_i = 32'h0000_5004;
      bif.host_re_i   = 1'b1;
      @(negedge clk);
      bif.host_re_i = 1'b0;
      n = 0;
      while (!(bif.bus_cached_o && !bif.bus_re_o) && (n < 20)) begin
         @(negedge clk);
         n++;
      end
      check_val("rstget_seen", 32'(n < 20), 32'd1);
      rstn = 1'b0;
      #1;
      check_val("rstget_cached", 32'(bif.bus_cached_o), 32'd0);
      check_val("rstget_re",     32'(bif.bus_re_o),     32'd0);
      check_val("rstget_baddr",  bif.bus_addr_o,        32'd0);
      check_val("rstget_ack",    32'(bif.host_ack_o | bif.host_err_o), 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
`ifdef CELLRV32_ICACHE_STATS_EN
      check_val("rst2_stat_hit",  stat_hit,  32'd0);
      check_val("rst2_stat_miss", stat_miss, 32'd0);
`endif
      expect_fetch("after_rst", 32'h0000_5004, 1, 1'b0);
      expect_fetch("after_rst_hit", 32'h0000_500C, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/cellrv32_icache_nway.md
Name: cellrv32_icache_nway

Overview:
Parametrised N-way set-associative instruction cache (1, 2 or 4 ways) with tree pseudo-LRU replacement and an uncached address window that bypasses the cache.
- Sits between the CPU instruction fetch interface and the processor bus, in the same place as the current i-cache.
- Tag, valid, status and data arrays are internal.
- Adds behaviour the previous generation lacks: 4-way associativity, invalid-way-first victim selection, uncached pass-through and optional hit/miss statistics.

Parameters:
- ICACHE_NUM_LINES, 8: lines (index sets) per way; power of 2, min 1.
- ICACHE_BLOCK_SIZE, 64: block size in bytes; power of 2, min 4.
- ICACHE_NUM_WAYS, 2: associativity; legal values 1, 2 or 4; any other value raises an elaboration $error.
- ICACHE_UC_BEGIN, 4'hF: accesses with host_addr_i[31:28] >= this value are uncached.

Ports:
- clk_i  in  1  global clock, rising edge.
- rstn_i  in  1  global reset, asynchronous, active-low.
- clear_i  in  1  invalidate-all request (single-cycle pulse).
- miss_o  out  1  high for exactly 1 cycle when a cached miss is detected.
- host_addr_i  in  32  fetch address; held stable by the host from host_re_i until ack/err.
- host_rdata_o  out  32  read data; valid only in the ack cycle.
- host_re_i  in  1  read request pulse.
- host_ack_o  out  1  transfer done.
- host_err_o  out  1  transfer error.
- bus_cached_o  out  1  high while a block refill is in progress.
- bus_addr_o  out  32  bus address.
- bus_rdata_i  in  32  bus read data.
- bus_re_o  out  1  bus read request pulse.
- bus_ack_i  in  1  bus acknowledge.
- bus_err_i  in  1  bus error.
- Statistics ports: present only with the macro in Optional Feature.

Behaviour:
- Address split: offset = log2(BLOCK_SIZE/4) word bits above bits [1:0]; then log2(NUM_LINES) index bits; the remainder is the tag.
- Reset values:
  - All outputs 0.
  - State S_CLEAR.
  - Buffered request and buffered clear both 0.
  - Valid bits and PLRU bits are cleared by S_CLEAR in the cycle after reset release; data/tag arrays have no reset.
- Request buffering: host_re_i is OR-buffered while the FSM is busy, so a request arriving in any non-IDLE state is served afterwards. clear_i is buffered the same way.
- States and transitions:
  - S_IDLE:
    - If clear is buffered: go to S_CLEAR (clear has priority over a simultaneous read).
    - Else if a read is pending and the address is uncached: go to S_UC_REQ.
    - Else if a read is pending: go to S_CHECK.
  - S_CLEAR: clear all valid and PLRU bits in 1 cycle; drop the clear buffer; go to S_IDLE.
  - S_CHECK: tags of all ways are compared against the registered array read, one cycle after the request.
    - Hit: ack (or err if the stored word status is set) in this cycle, update PLRU toward the hit way, go to S_IDLE.
    - Hit latency is 2 cycles from host_re_i (re in IDLE, ack in CHECK).
    - Miss: go to S_MISS.
  - S_MISS: assert miss_o; latch the block-aligned address; choose the victim way:
    - the lowest-index invalid way if any;
    - else the PLRU way (2-way: 1 bit per line; 4-way: 3-bit tree per line).
  - S_REQ: bus_re_o=1, bus_cached_o=1; go to S_GET.
  - S_GET: bus_cached_o=1.
    - On bus_ack_i or bus_err_i: write the word and its error status into the victim way.
    - If this was the last word: write the tag, set valid, update PLRU toward the victim, go to S_RESYNC0.
    - Else: address += 4 (wraps only within the block), go to S_REQ.
  - S_RESYNC0: array read latency; go to S_RESYNC1.
  - S_RESYNC1: ack or err from the stored status; go to S_IDLE.
  - S_UC_REQ: bus_re_o=1 with bus_addr_o = host_addr_i word-aligned; bus_cached_o=0; go to S_UC_GET.
  - S_UC_GET: forward bus_rdata_i; host_ack_o = bus_ack_i, host_err_o = bus_err_i; go to S_IDLE on either. No allocation and no PLRU change.
- Refill rules:
  - A refill word that returned an error still validates the block; later hits on that word return host_err_o.
  - A clear_i during a refill is buffered and applied in the next S_IDLE, after the ack.
  - The refilled block is therefore invalidated before any further hit.
- Defensive rules:
  - If bus_ack_i and bus_err_i arrive together, the error takes precedence.
  - Undefined states go to S_IDLE.
  - Asserting rstn_i low mid-refill returns the FSM to S_CLEAR asynchronously, drops bus_re_o immediately and discards the partial block.
- ICACHE_NUM_WAYS=1 degenerates to direct-mapped with no PLRU storage.

Optional Feature:
- Macro: CELLRV32_ICACHE_STATS_EN.
- Defined: adds outputs stat_hit_o[31:0] and stat_miss_o[31:0].
  - stat_hit_o increments on each S_CHECK hit; stat_miss_o increments on each S_MISS.
  - Both saturate at 32'hFFFFFFFF.
  - Both reset to 0 on rstn_i and on S_CLEAR.
- Undefined: the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Cold fetch, 4 ways, 16 B blocks: re at 0x0000_0104 -> miss_o=1 once; bus reads 0x100, 0x104, 0x108, 0x10C; ack with the 0x104 word. Re-fetch 0x108 -> ack 2 cycles after re, no bus traffic.
- Five distinct tags mapping to index 0: fetch A, B, C, D, then A again, then E -> E evicts B (PLRU); re-fetch A hits, re-fetch B misses.
- bus_err_i on the 3rd refill word -> block valid; fetching that word gives host_err_o=1; fetching the neighbour word gives host_ack_o=1.
- Uncached fetch at 0xF000_0010 -> single bus_re_o at 0xF000_0010 with bus_cached_o=0; ack/err mirror the bus; a repeat fetch goes to the bus again.
- clear_i pulsed during S_GET -> current fetch acked normally; the next fetch of the same address misses. clear_i and host_re_i in the same IDLE cycle -> S_CLEAR first, then the read is served.
- rstn_i low during S_GET -> all outputs 0 immediately; after release, the first fetch misses. With the macro defined, the counters read 0.
